prog_mem_responder: RTL
=======================

Name: prog_mem_responder

Overview:
- Memory-side responder for the 8-bit processor bus. It answers the CPU's address, write-data, read-data and write strobe with a 256x8 storage array.
- It also contains a byte-stream program loader. The loader fills memory while holding the CPU in reset, then releases it.
- It sits between the CPU and the board-level byte source (UART receiver or testbench). Its cpu_hold output is ORed into the CPU reset at top level.

Parameters:
- ADDR_W, 8, address width of the storage array and of all address ports.
- DATA_W, 8, data width of the storage array and of all data ports.
- DEPTH, 256, number of words; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- mem_addr  in  ADDR_W  CPU address (driven from the CPU's AR register).
- mem_din  in  DATA_W  CPU write data (the CPU bus).
- mem_write  in  1  CPU write strobe, level-sampled at clk edge.
- mem_dout  out  DATA_W  read data to the CPU.
- ld_start  in  1  one-cycle pulse that starts a load burst.
- ld_base  in  ADDR_W  first load address, sampled with ld_start.
- ld_count  in  ADDR_W  number of bytes to load, sampled with ld_start; 0 means DEPTH.
- ld_valid  in  1  load byte valid.
- ld_data  in  DATA_W  load byte.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_done  out  1  one-cycle pulse when the last byte of a burst is written.
- run_go  in  1  one-cycle pulse that releases the CPU.
- cpu_hold  out  1  hold CPU in reset.
- wr_blocked  out  1  sticky flag: a CPU write arrived while held.

Behaviour:
- Reset values:
  - state = HOLD, cpu_hold = 1, ld_ready = 0, ld_done = 0, wr_blocked = 0.
  - Internal ptr = 0, remaining = 0.
  - Storage contents are not cleared by reset.
- Read path:
  - mem_dout = mem[mem_addr], combinational (asynchronous read).
  - Zero-cycle latency, so the CPU captures the addressed word in the cycle after it loads its address register.
  - Read and write to the same address in the same cycle: mem_dout shows the old data; new data is visible after the edge.
- CPU write:
  - In RUN, with mem_write=1 at the clk edge, mem[mem_addr] <= mem_din.
  - In HOLD or LOAD, a CPU write is ignored and sets wr_blocked=1.
  - wr_blocked clears only on reset.
- State machine states: HOLD, LOAD, RUN.
- HOLD:
  - cpu_hold=1, ld_ready=0.
  - ld_start: go to LOAD; ptr <= ld_base; remaining <= (ld_count==0 ? DEPTH : ld_count).
  - Else run_go: go to RUN.
  - ld_start and run_go in the same cycle: ld_start wins and run_go is dropped.
- LOAD:
  - cpu_hold=1, ld_ready=1.
  - On ld_valid && ld_ready: mem[ptr] <= ld_data; ptr <= ptr+1, wrapping modulo DEPTH (255 -> 0); remaining <= remaining-1.
  - When the accepted byte has remaining==1: ld_done=1 on the next cycle (registered, one-cycle pulse) and the state goes to HOLD.
  - ld_start and run_go are ignored in LOAD.
  - ld_valid with no handshake (outside LOAD) is ignored; data is dropped.
- RUN:
  - cpu_hold=0, ld_ready=0.
  - ld_start: go to LOAD (cpu_hold reasserts the next cycle) with the same sampling as in HOLD. A CPU write in that same cycle still commits, because the state is still RUN.
  - run_go is ignored in RUN.
- Reset mid-LOAD:
  - State goes to HOLD and the burst is abandoned.
  - Bytes already written remain; no ld_done is produced.
- Width rules:
  - remaining is ADDR_W+1 bits so that DEPTH fits.
  - ptr is ADDR_W bits and wraps naturally.

Test Plan:
- Reset, then ld_start with ld_base=0x00, ld_count=4, then bytes 0x11,0x22,0x33,0x44 streamed with ld_valid held high -> mem[0..3] hold those bytes; ld_done pulses once, exactly one cycle after the 0x44 accept; cpu_hold stays 1 throughout.
- Load with ld_base=0xFE, ld_count=3, bytes A,B,C -> mem[0xFE]=A, mem[0xFF]=B, mem[0x00]=C (wrap); ld_valid toggled 1,0,1,0,1 -> exactly 3 accepts.
- run_go after a load; cpu_hold falls the next cycle; CPU write mem_addr=0x40, mem_din=0x5A -> mem_dout at addr 0x40 reads 0x5A after the edge; same-cycle read shows the old value.
- In HOLD, mem_write=1 at addr 0x10 with data 0x99 -> mem[0x10] unchanged; wr_blocked=1 and stays 1 until reset.
- ld_start and run_go in the same cycle in HOLD -> LOAD entered, cpu_hold stays 1; ld_count=0 -> 256 bytes accepted before ld_done.
- Reset asserted after 2 of 5 load bytes -> state HOLD, ld_ready=0, no ld_done, the first 2 bytes retained in memory.

Source files
------------

// File: rtl/prog_mem_responder_if.sv
// CPU memory bus plus program-loader byte stream and run control.
// master = CPU / board side, slave = memory responder.
interface prog_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dout;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_base;
    logic [ADDR_W-1:0] ld_count;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              ld_done;
    logic              run_go;
    logic              cpu_hold;
    logic              wr_blocked;

    modport master (
        output mem_addr, mem_din, mem_write,
        output ld_start, ld_base, ld_count,
        output ld_valid, ld_data, run_go,
        input  mem_dout, ld_ready, ld_done,
        input  cpu_hold, wr_blocked
    );

    modport slave (
        input  mem_addr, mem_din, mem_write,
        input  ld_start, ld_base, ld_count,
        input  ld_valid, ld_data, run_go,
        output mem_dout, ld_ready, ld_done,
        output cpu_hold, wr_blocked
    );
endinterface

// File: rtl/prog_mem_responder.sv
// 256x8 CPU memory with a byte-stream program loader that holds
// the CPU in reset while a burst is written.
module prog_mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input logic                 clk,
    input logic                 reset,
    prog_mem_responder_if.slave bus
);
    localparam logic [1:0] S_HOLD = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rem;
    logic              r_done;
    logic              r_wr_blocked;

    logic              w_load;
    logic              w_run;
    logic              w_accept;
    logic              w_last;
    logic              w_cpu_wr;
    logic [ADDR_W:0]   w_new_rem;

    assign w_load    = (r_state == S_LOAD);
    assign w_run     = (r_state == S_RUN);
    assign w_accept  = w_load && bus.ld_valid;
    assign w_last    = w_accept && (r_rem == ONE);
    assign w_cpu_wr  = w_run && bus.mem_write;
    assign w_new_rem = (bus.ld_count == '0) ? FULL
                                             : {1'b0, bus.ld_count};

    assign bus.mem_dout   = r_mem[bus.mem_addr];
    assign bus.ld_ready   = w_load;
    assign bus.ld_done    = r_done;
    assign bus.cpu_hold   = !w_run;
    assign bus.wr_blocked = r_wr_blocked;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_HOLD;
            r_ptr        <= '0;
            r_rem        <= '0;
            r_done       <= 1'b0;
            r_wr_blocked <= 1'b0;
        end else begin
            r_done <= w_last;
            if (bus.mem_write && !w_run)
                r_wr_blocked <= 1'b1;
            case (r_state)
                S_HOLD, S_RUN: begin
                    // ld_start outranks run_go when both arrive together
                    if (bus.ld_start) begin
                        r_state <= S_LOAD;
                        r_ptr   <= bus.ld_base;
                        r_rem   <= w_new_rem;
                    end else if (bus.run_go && r_state == S_HOLD) begin
                        r_state <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_rem <= r_rem - ONE;
                        if (w_last)
                            r_state <= S_HOLD;
                    end
                end
                default: r_state <= S_HOLD;
            endcase
        end
    end

    // Loader and CPU writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_accept)
                r_mem[r_ptr] <= bus.ld_data;
            else if (w_cpu_wr)
                r_mem[bus.mem_addr] <= bus.mem_din;
        end
    end
endmodule
